stopwatch_key_ctrl: RTL and testbench
=====================================

# stopwatch_key_ctrl

Key-conditioning stage between the raw, active-low board push-buttons and the stopwatch counter chain. It synchronises and debounces three keys. It produces a run/stop level for the counters' count enable, a one-cycle load strobe and a one-cycle clear strobe. It replaces direct KEY wiring into the counters, so contact bounce never reaches their enable or load inputs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz).
- LONG_PRESS_CYCLES, 50000000: hold time for clear when STOPWATCH_LONGPRESS_EN is defined (1 s at 50 MHz).

Ports:
- clk  in  1  system clock (CLOCK_50 at top level); all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- KEY  in  3  raw push-buttons, active-low, asynchronous to clk. [0] = start/stop, [1] = load, [2] = clear.
- key_state  out  3  debounced key levels, active-high (1 = pressed).
- run  out  1  count enable level for the stopwatch counters.
- load_pulse  out  1  one-cycle strobe, asserted on an accepted KEY[1] press.
- clr_pulse  out  1  one-cycle strobe, asserted on an accepted KEY[2] press (or long press; see Configuration).

## Operation
- Each key passes through a 2-flop synchroniser and is inverted to active-high, then enters its own debounce FSM.
- Debounce FSM states and transitions:
  - RELEASED: synced=1 -> PRESS_WAIT; counter loads 0.
  - PRESS_WAIT: synced=0 -> RELEASED. Otherwise the counter increments; at DEBOUNCE_CYCLES-1 -> PRESSED and press_evt fires for 1 cycle.
  - PRESSED: synced=0 -> RELEASE_WAIT; counter loads 0.
  - RELEASE_WAIT: synced=1 -> PRESSED. Otherwise the counter increments; at DEBOUNCE_CYCLES-1 -> RELEASED.
- key_state[i] is 1 in PRESSED and RELEASE_WAIT, and 0 otherwise.
- run toggles on the KEY[0] press_evt.
- load_pulse equals the registered KEY[1] press_evt.
- clr_pulse equals the registered KEY[2] press_evt. When clr_pulse fires, run is also forced to 0 on the same edge.
- Simultaneous KEY[0] and KEY[2] press_evt in the same cycle: clear wins and run becomes 0.
- load_pulse is independent of run and clear. All three strobes may assert in the same cycle.
- Holding a key produces exactly one strobe per press. There is no auto-repeat.
- Counter width is clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)). The counter saturates and never wraps.

## Timing
- Reset values: all FSMs RELEASED, counters 0, synchroniser flops 0 (released after inversion), key_state=0, run=0, load_pulse=0, clr_pulse=0.
- rst asserted mid-debounce or mid-press discards progress. A key still held after rst deasserts must again be stable for DEBOUNCE_CYCLES before it is accepted.
- Press latency: the first clk edge sampling KEY low is edge 0. press_evt is asserted in the cycle after edge 2+DEBOUNCE_CYCLES. The registered strobe, or the run change, is visible one cycle later: 3+DEBOUNCE_CYCLES edges in total.
- Any bounce resets the stability count. Acceptance needs DEBOUNCE_CYCLES uninterrupted cycles.
- Strobes are high for exactly one clk cycle.

## Configuration
- STOPWATCH_LONGPRESS_EN defined:
  - clr_pulse fires once when KEY[2] has remained PRESSED for LONG_PRESS_CYCLES cycles after acceptance.
  - Releasing earlier produces no clear.
  - A continued hold does not re-fire.
- Not defined: clr_pulse fires on the KEY[2] press_evt, with the latency given above.
- LONG_PRESS_CYCLES is ignored when the macro is not defined.

## Structure
- Shared package:
  - Debounce state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - Key index constants KEY_RUN=0, KEY_LOAD=1, KEY_CLR=2.
  - clog2 helper function.
- Sub-module key_debounce: one instance per key, containing the synchroniser, FSM, counter, key_state bit and press_evt. It takes the DEBOUNCE_CYCLES parameter.
- The top level holds the run register, the strobe registers and the optional long-press counter.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=16.
- Reset: hold rst 3 cycles with all KEY=1 -> key_state=000, run=0, no strobes; outputs stay quiet for 50 cycles.
- Clean KEY[0] press held 20 cycles:
  - run rises exactly 7 edges after the first low sample.
  - key_state[0]=1.
  - Release, then a second press -> run returns to 0.
- Bounce: KEY[1] toggles low/high every 2 cycles for 20 cycles, then stays low -> no load_pulse during the bounce; exactly one load_pulse 7 cycles after the final low.
- Simultaneous: run=1; KEY[0] and KEY[2] pressed on the same edge -> clr_pulse=1 for 1 cycle and run=0 on the same edge.
- Reset mid-debounce: KEY[1] low for 3 cycles, then 1 cycle of rst, KEY still low -> load_pulse appears 7 cycles after rst deasserts, not earlier.
- STOPWATCH_LONGPRESS_EN defined:
  - KEY[2] held 10 cycles after acceptance, then released -> no clr_pulse.
  - KEY[2] held 30 cycles -> exactly one clr_pulse, 16 cycles after acceptance.

Source files
------------

// File: rtl/stopwatch_key_ctrl_pkg.sv
// Shared types and constants for the stopwatch key-conditioning block.
package stopwatch_key_ctrl_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    localparam int NUM_KEYS = 3;
    localparam int KEY_RUN  = 0;
    localparam int KEY_LOAD = 1;
    localparam int KEY_CLR  = 2;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stopwatch_key_ctrl_if.sv
// Key/strobe bundle between the board buttons and the stopwatch counter chain.
interface stopwatch_key_ctrl_if;
    logic [2:0] KEY;
    logic [2:0] key_state;
    logic       run;
    logic       load_pulse;
    logic       clr_pulse;

    modport master (
        output KEY,
        input  key_state, run, load_pulse, clr_pulse
    );

    modport slave (
        input  KEY,
        output key_state, run, load_pulse, clr_pulse
    );
endinterface

// File: rtl/stopwatch_key_ctrl_key_debounce.sv
// One key: 2-flop synchroniser, debounce FSM with stability counter, one-cycle press event.
module key_debounce
    import stopwatch_key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic key_state_o,
    output logic held_o,
    output logic press_evt_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       sync_q;
    logic             synced;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             evt_q, evt_d;

    assign synced  = sync_q[1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            state_q <= RELEASED;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], ~key_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        case (state_q)
            RELEASED: begin
                if (synced) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!synced) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    evt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!synced) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (synced) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    assign key_state_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign held_o      = (state_q == PRESSED);
    assign press_evt_o = evt_q;

endmodule

// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch key conditioning: debounced run/stop level plus load and clear strobes.
// Optional STOPWATCH_LONGPRESS_EN: clear fires only after KEY[2] is held LONG_PRESS_CYCLES.
module stopwatch_key_ctrl
    import stopwatch_key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    stopwatch_key_ctrl_if.slave  bus
);

    localparam int CNT_W = clog2(max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES));

    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] press_evt;
    logic                clr_fire;
    logic                run_q, run_d;
    logic                load_q, load_d;
    logic                clr_q, clr_d;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk         (clk),
                .rst         (rst),
                .key_n_i     (bus.KEY[gi]),
                .key_state_o (key_state[gi]),
                .held_o      (held[gi]),
                .press_evt_o (press_evt[gi])
            );
        end
    endgenerate

`ifdef STOPWATCH_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

    logic             lp_armed_q, lp_armed_d;
    logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            lp_armed_q <= 1'b0;
            lp_cnt_q   <= '0;
        end else begin
            lp_armed_q <= lp_armed_d;
            lp_cnt_q   <= lp_cnt_d;
        end
    end

    // The press_evt cycle counts as the first held cycle; leaving PRESSED aborts.
    always_comb begin
        lp_armed_d = lp_armed_q;
        lp_cnt_d   = lp_cnt_q;
        clr_fire   = 1'b0;
        if (press_evt[KEY_CLR]) begin
            if (LP_LAST == '0) begin
                clr_fire = 1'b1;
            end else begin
                lp_armed_d = 1'b1;
                lp_cnt_d   = CNT_W'(1);
            end
        end else if (lp_armed_q) begin
            if (!held[KEY_CLR]) begin
                lp_armed_d = 1'b0;
            end else if (lp_cnt_q == LP_LAST) begin
                clr_fire   = 1'b1;
                lp_armed_d = 1'b0;
            end else begin
                lp_cnt_d = lp_cnt_q + 1'b1;
            end
        end
    end
`else
    logic unused_held;
    assign unused_held = ^held;
    assign clr_fire    = press_evt[KEY_CLR];
`endif

    // Clear overrides a same-cycle start/stop toggle.
    always_comb begin
        run_d = run_q;
        if (clr_fire) begin
            run_d = 1'b0;
        end else if (press_evt[KEY_RUN]) begin
            run_d = ~run_q;
        end
        load_d = press_evt[KEY_LOAD];
        clr_d  = clr_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            load_q <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            load_q <= load_d;
            clr_q  <= clr_d;
        end
    end

    assign bus.key_state  = key_state;
    assign bus.run        = run_q;
    assign bus.load_pulse = load_q;
    assign bus.clr_pulse  = clr_q;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Directed bench for stopwatch_key_ctrl: predicted strobe/run events are queued and matched on arrival.
module tb_stopwatch_key_ctrl;

    localparam int DEB = 4;
    localparam int LP  = 16;
    localparam int LAT = DEB + 4;   // drive-to-visible edges: 1 to first sample, then 3+DEB

    typedef struct {
        int         cyc;
        logic [2:0] sig;            // {run, load_pulse, clr_pulse}
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stopwatch_key_ctrl_if sw_if ();

    stopwatch_key_ctrl #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if)
    );

    exp_t exp_q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    logic mon_en = 1'b0;
    logic prev_run = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        logic [2:0] obs;
        exp_t       e;
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en) begin
            obs = {sw_if.run, sw_if.load_pulse, sw_if.clr_pulse};
            if (sw_if.load_pulse !== 1'b0 || sw_if.clr_pulse !== 1'b0 || sw_if.run !== prev_run) begin
                check("event_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_signals", 32'(obs), 32'(e.sig));
                end
            end
            prev_run = sw_if.run;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_evt(input int dly, input logic run_v, input logic load_v, input logic clr_v);
        exp_t e;
        e.cyc = cyc + dly;
        e.sig = {run_v, load_v, clr_v};
        exp_q.push_back(e);
        $display("queued event at cycle %0d run=%0b load=%0b clr=%0b", e.cyc, run_v, load_v, clr_v);
    endtask

    initial begin
        // Reset with all keys released
        sw_if.KEY = 3'b111;
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        check("rst_key_state", 32'(sw_if.key_state), 32'd0);
        check("rst_run", 32'(sw_if.run), 32'd0);
        check("rst_load", 32'(sw_if.load_pulse), 32'd0);
        check("rst_clr", 32'(sw_if.clr_pulse), 32'd0);
        prev_run = sw_if.run;
        mon_en   = 1'b1;
        ticks(50);
        check("idle_key_state", 32'(sw_if.key_state), 32'd0);
        check("idle_run", 32'(sw_if.run), 32'd0);

        // Clean start/stop press, release, second press stops
        sw_if.KEY[0] = 1'b0;
        expect_evt(LAT, 1'b1, 1'b0, 1'b0);
        ticks(20);
        check("held_key_state", 32'(sw_if.key_state), 32'd1);
        sw_if.KEY[0] = 1'b1;
        ticks(12);
        check("released_key_state", 32'(sw_if.key_state), 32'd0);
        check("run_after_release", 32'(sw_if.run), 32'd1);
        sw_if.KEY[0] = 1'b0;
        expect_evt(LAT, 1'b0, 1'b0, 1'b0);
        ticks(12);
        sw_if.KEY[0] = 1'b1;
        ticks(12);

        // Bouncing load key, then a stable press
        for (int i = 0; i < 10; i++) begin
            sw_if.KEY[1] = i[0];
            ticks(2);
        end
        sw_if.KEY[1] = 1'b0;
        expect_evt(LAT, 1'b0, 1'b1, 1'b0);
        ticks(15);
        check("load_held_key_state", 32'(sw_if.key_state), 32'd2);
        sw_if.KEY[1] = 1'b1;
        ticks(12);

        // Start, then start and clear together
        sw_if.KEY[0] = 1'b0;
        expect_evt(LAT, 1'b1, 1'b0, 1'b0);
        ticks(12);
        sw_if.KEY[0] = 1'b1;
        ticks(12);
        check("run_before_simul", 32'(sw_if.run), 32'd1);
        sw_if.KEY = 3'b010;
`ifdef STOPWATCH_LONGPRESS_EN
        expect_evt(LAT, 1'b0, 1'b0, 1'b0);
`else
        expect_evt(LAT, 1'b0, 1'b0, 1'b1);
`endif
        ticks(12);
        sw_if.KEY = 3'b111;
        ticks(15);
        check("run_after_simul", 32'(sw_if.run), 32'd0);

        // Reset in the middle of a load-key debounce
        sw_if.KEY[1] = 1'b0;
        ticks(3);
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        check("midrst_key_state", 32'(sw_if.key_state), 32'd0);
        expect_evt(LAT, 1'b0, 1'b1, 1'b0);
        ticks(15);
        sw_if.KEY = 3'b111;
        ticks(12);

`ifdef STOPWATCH_LONGPRESS_EN
        // Short hold: released 10 cycles after acceptance, no clear
        sw_if.KEY[2] = 1'b0;
        ticks(LAT - 1 + 10);
        sw_if.KEY[2] = 1'b1;
        ticks(30);
        // Long hold: one clear, LP cycles after acceptance
        sw_if.KEY[2] = 1'b0;
        expect_evt(LAT - 1 + LP, 1'b0, 1'b0, 1'b1);
        ticks(30);
        sw_if.KEY[2] = 1'b1;
        ticks(15);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
